// File: rtl/frame_filler_if.sv
// frame_filler_if: acquisition input, page-switch level and frame RAM write port
// of the frame filler, bundled for connection between producer and filler.
interface frame_filler_if #(
  parameter int IN_W   = 16,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
);
  logic [IN_W-1:0]   word;
  logic              ready;
  logic              bufSwitch;
  logic [DATA_W-1:0] outWDAT;
  logic              outWREN;
  logic [ADDR_W-1:0] outWADR;
  logic              ovf;

  // Driving side: supplies words, strobes and the page switch.
  modport master (
    output word, ready, bufSwitch,
    input  outWDAT, outWREN, outWADR, ovf
  );

  // Filler side: consumes words and drives the RAM write port.
  modport slave (
    input  word, ready, bufSwitch,
    output outWDAT, outWREN, outWADR, ovf
  );
endinterface

// File: rtl/frame_filler.sv
// frame_filler: buffers acquisition words in a show-ahead FIFO and writes
// frames (4 rotating sync-marker words + DATA_LEN data words) into the frame
// RAM. Reserved address slots are skipped; at the last address the writer
// waits for a page-switch toggle before wrapping to the first address.
// Build macro FRAME_FILLER_PARITY_EN: when defined, data words carry odd
// parity in their MSB; when undefined, data words are written raw.
module frame_filler #(
  parameter int          IN_W        = 16,
  parameter int          DATA_W      = 12,
  parameter int          ADDR_W      = 10,
  parameter int          FIFO_LOG2   = 10,
  parameter int          START_LEVEL = 1000,
  parameter int          DATA_LEN    = 124,
  parameter int          SKIP_LOG2   = 2,
  parameter int          SLOT_CYC    = 4,
  parameter logic [30:0] SYNC_M      = 31'b1111100110100100001010111011000,
  parameter logic [12:0] SYNC_B      = 13'b1111100110101
) (
  input  logic          clk,
  input  logic          reset,
  frame_filler_if.slave bus
);

  localparam int LVL_W  = FIFO_LOG2 + 1;
  localparam int SLOT_W = $clog2(SLOT_CYC);
  localparam int DIDX_W = $clog2(DATA_LEN + 1);

  localparam logic [ADDR_W-1:0] FIRST_ADR = (SKIP_LOG2 > 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST_ADR  = '1;
  localparam logic [ADDR_W-1:0] SKIP_MASK = ADDR_W'((1 << SKIP_LOG2) - 1);
  localparam logic [LVL_W-1:0]  START_LVL = LVL_W'(START_LEVEL);
  localparam logic [SLOT_W-1:0] STRB_LAST = SLOT_W'(SLOT_CYC - 2);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYC - 1);
  localparam logic [DIDX_W-1:0] DATA_LAST = DIDX_W'(DATA_LEN - 1);

  typedef enum logic [1:0] {IDLE, MARK, DATA, WAIT_SW} state_t;

  // Next RAM address: +1, or +2 when +1 would land on a reserved slot.
  function automatic logic [ADDR_W-1:0] adr_advance(input logic [ADDR_W-1:0] adr);
    logic [ADDR_W-1:0] nxt;
    nxt = adr + ADDR_W'(1);
    if ((SKIP_LOG2 > 0) && ((nxt & SKIP_MASK) == '0))
      nxt = adr + ADDR_W'(2);
    return nxt;
  endfunction

  // Marker word idx (MSB-first) of the 44-bit field {M,B} in variant var_sel.
  function automatic logic [DATA_W-1:0] marker_word(input logic [1:0] var_sel,
                                                    input logic [1:0] idx);
    logic [43:0] field;
    logic [10:0] w;
    field = {SYNC_M ^ {31{var_sel[0]}}, SYNC_B ^ {13{var_sel[1]}}};
    case (idx)
      2'd0:    w = field[43:33];
      2'd1:    w = field[32:22];
      2'd2:    w = field[21:11];
      default: w = field[10:0];
    endcase
    return {{(DATA_W-11){1'b0}}, w};
  endfunction

  // Data word as written to RAM; optionally the MSB becomes odd parity.
  function automatic logic [DATA_W-1:0] data_word(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] d;
    d = w;
`ifdef FRAME_FILLER_PARITY_EN
    d[DATA_W-1] = ~^w[DATA_W-2:0];
`endif
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers: ready_p0/p1 resolve metastability, p2 is edge history.
  // ---------------------------------------------------------------------------
  logic ready_p0, ready_p1, ready_p2;
  logic sw_p0, sw_p1, sw_p2;
  logic push, toggle;

  // Two-flop synchronisers plus one history flop for ready and bufSwitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_p0 <= 1'b0;
      ready_p1 <= 1'b0;
      ready_p2 <= 1'b0;
      sw_p0    <= 1'b0;
      sw_p1    <= 1'b0;
      sw_p2    <= 1'b0;
    end else begin
      ready_p0 <= bus.ready;
      ready_p1 <= ready_p0;
      ready_p2 <= ready_p1;
      sw_p0    <= bus.bufSwitch;
      sw_p1    <= sw_p0;
      sw_p2    <= sw_p1;
    end
  end

  assign push   = ready_p1 & ~ready_p2;
  assign toggle = sw_p1 ^ sw_p2;

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO: head is always the oldest stored word.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]    mem [1 << FIFO_LOG2];
  logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level;
  logic                 full, empty, pop, push_ok, ovf_q;
  logic [DATA_W-1:0]    head;

  assign full    = level[FIFO_LOG2];
  assign empty   = (level == '0);
  assign push_ok = push && (!full || pop);
  assign head    = mem[rd_ptr];

  // FIFO storage; a push into a full FIFO is accepted only alongside a pop.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= bus.word[DATA_W-1:0];
  end

  // FIFO pointers, fill level and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)
        level <= level + 1'b1;
      else if (pop && !push_ok)
        level <= level - 1'b1;
      if (push && full && !pop)
        ovf_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame writer FSM
  // ---------------------------------------------------------------------------
  state_t            state, state_d, ret_state, ret_d, next_phase;
  logic [SLOT_W-1:0] slot_cnt, slot_d;
  logic [1:0]        mark_idx, mark_d, vsel, vsel_d;
  logic [DIDX_W-1:0] data_idx, data_d;
  logic              pend;
  logic [DATA_W-1:0] wdat, wdat_d;
  logic              wren, wren_d;
  logic [ADDR_W-1:0] wadr, wadr_d;

  // State register with slot position, frame word counters and variant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ret_state <= MARK;
      slot_cnt  <= '0;
      mark_idx  <= '0;
      data_idx  <= '0;
      vsel      <= '0;
    end else begin
      state     <= state_d;
      ret_state <= ret_d;
      slot_cnt  <= slot_d;
      mark_idx  <= mark_d;
      data_idx  <= data_d;
      vsel      <= vsel_d;
    end
  end

  // Next state: slot sequencing, frame word counting, page-end pause.
  always_comb begin
    state_d    = state;
    ret_d      = ret_state;
    slot_d     = slot_cnt;
    mark_d     = mark_idx;
    data_d     = data_idx;
    vsel_d     = vsel;
    next_phase = state;
    case (state)
      IDLE: begin
        if (level >= START_LVL) begin
          state_d = MARK;
          slot_d  = '0;
        end
      end
      MARK, DATA: begin
        if (state == DATA && slot_cnt == '0 && empty) begin
          slot_d = '0;
        end else if (slot_cnt != SLOT_LAST) begin
          slot_d = slot_cnt + 1'b1;
        end else begin
          slot_d = '0;
          if (state == MARK) begin
            if (mark_idx == 2'd3) begin
              mark_d     = 2'd0;
              vsel_d     = vsel + 2'd1;
              next_phase = DATA;
            end else begin
              mark_d = mark_idx + 2'd1;
            end
          end else begin
            if (data_idx == DATA_LAST) begin
              data_d     = '0;
              next_phase = MARK;
            end else begin
              data_d = data_idx + 1'b1;
            end
          end
          if (wadr == LAST_ADR) begin
            state_d = WAIT_SW;
            ret_d   = next_phase;
          end else begin
            state_d = next_phase;
          end
        end
      end
      WAIT_SW: begin
        if (toggle || pend) begin
          state_d = ret_state;
          slot_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next-values: load data at slot cycle 0, strobe, advance address.
  always_comb begin
    wdat_d = wdat;
    wren_d = wren;
    wadr_d = wadr;
    pop    = 1'b0;
    case (state)
      MARK: begin
        if (slot_cnt == '0) begin
          wdat_d = marker_word(vsel, mark_idx);
          wren_d = 1'b1;
        end
      end
      DATA: begin
        if (slot_cnt == '0 && !empty) begin
          wdat_d = data_word(head);
          wren_d = 1'b1;
          pop    = 1'b1;
        end
      end
      WAIT_SW: begin
        if (toggle || pend)
          wadr_d = FIRST_ADR;
      end
      default: ;
    endcase
    if (state == MARK || state == DATA) begin
      if (slot_cnt == STRB_LAST)
        wren_d = 1'b0;
      if (slot_cnt == SLOT_LAST && wadr != LAST_ADR)
        wadr_d = adr_advance(wadr);
    end
  end

  // Registered RAM write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdat <= '0;
      wren <= 1'b0;
      wadr <= FIRST_ADR;
    end else begin
      wdat <= wdat_d;
      wren <= wren_d;
      wadr <= wadr_d;
    end
  end

  // Pending page switch: a toggle seen outside WAIT_SW is remembered once.
  always_ff @(posedge clk) begin
    if (reset)
      pend <= 1'b0;
    else if (state == WAIT_SW)
      pend <= 1'b0;
    else if (toggle)
      pend <= 1'b1;
  end

  assign bus.outWDAT = wdat;
  assign bus.outWREN = wren;
  assign bus.outWADR = wadr;
  assign bus.ovf     = ovf_q;

endmodule
